ram_drain: RTL and testbench

//  Downstream stage of the element-wise add engine. After the engine raises finish, this block

---
 rtl/ram_drain_pkg.sv | 19 +
 rtl/ram_drain_if.sv | 35 +++
 rtl/ram_drain_skid.sv | 79 +++++++
 rtl/ram_drain.sv | 184 ++++++++++++++++++
 tb/tb_ram_drain.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_drain_pkg.sv
// ram_drain_pkg
//   Shared types and helpers for the RAM drain stage.
//   - state_t : drain FSM state (IDLE, RUN, DONE), 2 bits
//   - SUM_W   : width of the optional running sum (RAM_DRAIN_SUM_EN)
package ram_drain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // DEPTH = 2**addr_w beats of at most 2**data_w-1 each, so data_w+addr_w
    // bits hold the full sum without overflow.
    function automatic int SUM_W(input int data_w, input int addr_w);
        return data_w + addr_w;
    endfunction

endpackage

// File: rtl/ram_drain_if.sv
// ram_drain_if
//   Output stream from the drain stage toward the host DMA.
//   Signals:
//     m_data  - beat payload (DATA_W)
//     m_valid - beat present
//     m_ready - consumer can take the beat
//     m_last  - beat is the final word of the RAM
//   Modports: master (drain stage), slave (DMA side).
//
// Handshake: a beat transfers on a rising clock edge where m_valid and
// m_ready are both high. Once m_valid rises it stays high, and m_data/m_last
// stay constant, until that transfer happens; m_valid never depends on
// m_ready, while m_ready may depend on m_valid.
interface ram_drain_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/ram_drain_skid.sv
// ram_drain_skid
//   Two-entry FIFO that holds RAM read data until the stream accepts it.
//   Ports:
//     clock, reset_n - clock, asynchronous active-low reset
//     push, push_data - write one entry
//     pop             - retire the head entry
//     head            - current head entry (valid when !empty)
//     full, empty     - occupancy flags
//     count           - occupancy 0..2
//   Push while full is only honoured when a pop happens on the same edge.
//   Pop while empty is ignored.
module ram_drain_skid #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push;
    logic         do_pop;

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        // Simultaneous push and pop leaves occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ram_drain.sv
// ram_drain
//   Reads the add engine's DEPTH-word result RAM in address order once the
//   engine is finished, and streams each word out with full backpressure.
//   Ports:
//     clock, reset_n - clock, asynchronous active-low reset
//     start          - begin a drain; honoured only in IDLE or DONE
//     finish         - high while in DONE (all DEPTH beats accepted)
//     rd_en, rd_addr - synchronous RAM read request
//     rd_data        - RAM data, valid the cycle after rd_en
//     m              - output stream (ram_drain_if master)
//     sum            - running sum of accepted beats (RAM_DRAIN_SUM_EN only)
//     dbg_state      - current FSM state
//   Optional feature macro: RAM_DRAIN_SUM_EN (running sum accumulator).
module ram_drain
    import ram_drain_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               start,
    output logic                               finish,
    output logic                               rd_en,
    output logic [ADDR_W-1:0]                  rd_addr,
    input  logic [DATA_W-1:0]                  rd_data,
    ram_drain_if.master                        m,
`ifdef RAM_DRAIN_SUM_EN
    output logic [SUM_W(DATA_W, ADDR_W)-1:0]   sum,
`endif
    output state_t                             dbg_state
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic              inflight_q, inflight_d;

    logic              issue;
    logic              start_run;
    logic              handshake;
    logic              last_beat;
    logic [2:0]        occ_after_pop;

    logic [DATA_W-1:0] skid_head;
    logic              skid_full;
    logic              skid_empty;
    logic [1:0]        skid_count;

    // Read data lands in the skid buffer one cycle after its rd_en.
    ram_drain_skid #(
        .W (DATA_W)
    ) u_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight_q),
        .push_data (rd_data),
        .pop       (handshake),
        .head      (skid_head),
        .full      (skid_full),
        .empty     (skid_empty),
        .count     (skid_count)
    );

    // Beats leave in address order, so the head is always beat number beat_q.
    assign last_beat = ~skid_empty & (beat_q == LAST_BEAT);
    assign handshake = ~skid_empty & m.m_ready;

    assign m.m_valid = ~skid_empty;
    assign m.m_data  = skid_head;
    assign m.m_last  = last_beat;

    assign rd_en     = issue;
    assign rd_addr   = addr_q;
    assign finish    = (state_q == DONE);
    assign dbg_state = state_q;

    always_comb begin
        state_d       = state_q;
        issued_d      = issued_q;
        addr_d        = addr_q;
        beat_d        = beat_q;
        issue         = 1'b0;
        start_run     = 1'b0;
        // Entries held after this edge's pop plus the read still in flight;
        // counting the pop keeps one beat per cycle under m_ready=1.
        occ_after_pop = 3'(skid_count) + 3'(inflight_q) - 3'(handshake);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    start_run = 1'b1;
                end
            end

            RUN: begin
                issue = (issued_q < DEPTH_CNT) & ~skid_full & (occ_after_pop < 3'd2);
                if (issue) begin
                    issued_d = issued_q + 1'b1;
                    // Address parks on the final word rather than wrapping.
                    if (addr_q != LAST_ADDR) begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                if (handshake) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                if (start) begin
                    state_d   = RUN;
                    start_run = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_run) begin
            issued_d = '0;
            addr_d   = '0;
            beat_d   = '0;
        end

        inflight_d = issue;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            issued_q   <= '0;
            addr_q     <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef RAM_DRAIN_SUM_EN
    localparam int SUM_WIDTH = SUM_W(DATA_W, ADDR_W);

    logic [SUM_WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start_run) begin
            sum_d = '0;
        end else if (handshake) begin
            sum_d = sum_q + SUM_WIDTH'(skid_head);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;
`endif

endmodule

// File: tb/tb_ram_drain.sv
// tb_ram_drain
//   Directed-plus-random bench for ram_drain. A behavioural RAM answers read
//   requests, a negedge monitor records accepted beats and stream-rule
//   violations, and the main sequence compares them against the RAM contents.
module tb_ram_drain;
    import ram_drain_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic start   = 1'b0;
    always #5 clock = ~clock;

    logic              finish;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    state_t            dbg_state;
`ifdef RAM_DRAIN_SUM_EN
    logic [DATA_W+ADDR_W-1:0] sum;
`endif

    ram_drain_if #(.DATA_W(DATA_W)) s_if ();

    ram_drain #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .finish    (finish),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .m         (s_if),
`ifdef RAM_DRAIN_SUM_EN
        .sum       (sum),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- behavioural RAM ----------------
    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge clock) begin
        if (rd_en) rd_data <= ram[rd_addr];
    end

    // ---------------- ready driver ----------------
    int ready_mode = 1;   // 0 low, 1 high, 2 toggle, 3 random
    initial begin
        s_if.m_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       s_if.m_ready = 1'b0;
                1:       s_if.m_ready = 1'b1;
                2:       s_if.m_ready = ~s_if.m_ready;
                default: s_if.m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] got_q[$];
    int                last_idx_q[$];
    int                hs_cyc_q[$];
    int                rd_addr_q[$];
    int                cyc = 0;
    int                first_rd = -1;
    int                fin_cyc = -1;
    int                occ = 0;   // words held downstream of the RAM
    int                infl = 0;  // read issued last cycle, data not yet buffered
    int                stab_err = 0;
    int                room_err = 0;
    int                valid_err = 0;
    bit                prev_stall = 1'b0;
    bit                prev_fin = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic              prev_last;

    always @(negedge clock) begin
        int hs;
        cyc++;
        if (!reset_n) begin
            occ        = 0;
            infl       = 0;
            prev_stall = 1'b0;
            prev_fin   = 1'b0;
        end else begin
            hs = (s_if.m_valid === 1'b1 && s_if.m_ready === 1'b1) ? 1 : 0;
            if (prev_stall && (s_if.m_valid !== 1'b1 || s_if.m_data !== prev_data ||
                               s_if.m_last !== prev_last))
                stab_err++;
            if (s_if.m_valid !== ((occ > 0) ? 1'b1 : 1'b0)) valid_err++;
            if (rd_en === 1'b1) begin
                if (occ >= 2 || occ + infl - hs >= 2) room_err++;
                rd_addr_q.push_back(int'(rd_addr));
                if (first_rd < 0) first_rd = cyc;
            end
            if (hs == 1) begin
                if (s_if.m_last === 1'b1) last_idx_q.push_back(got_q.size());
                got_q.push_back(s_if.m_data);
                hs_cyc_q.push_back(cyc);
            end
            if (finish === 1'b1 && !prev_fin && fin_cyc < 0) fin_cyc = cyc;
            prev_fin   = (finish === 1'b1);
            occ        = occ + infl - hs;
            infl       = (rd_en === 1'b1) ? 1 : 0;
            prev_stall = (s_if.m_valid === 1'b1) && (s_if.m_ready !== 1'b1);
            prev_data  = s_if.m_data;
            prev_last  = s_if.m_last;
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        got_q.delete();
        last_idx_q.delete();
        hs_cyc_q.delete();
        rd_addr_q.delete();
        first_rd  = -1;
        fin_cyc   = -1;
        stab_err  = 0;
        room_err  = 0;
        valid_err = 0;
    endtask

    int t0;
    task automatic pulse_start();
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        t0 = cyc;
        #1 start = 1'b0;
    endtask

    task automatic wait_finish(input string tag);
        int n = 0;
        while (finish !== 1'b1 && n < 1000) begin
            @(posedge clock);
            #2;
            n++;
        end
        check({tag, "_finish"}, 64'(finish), 64'(1));
        @(negedge clock);
        #1;
    endtask

    task automatic check_stream(input string tag);
        logic [DATA_W-1:0] exp_q[$];
        logic [63:0]       exp_sum;
        exp_sum = 64'd0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(ram[i]);
            exp_sum += 64'(ram[i]);
        end
        check({tag, "_beats"}, 64'(got_q.size()), 64'(DEPTH));
        for (int i = 0; i < DEPTH && i < got_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        check({tag, "_last_count"}, 64'(last_idx_q.size()), 64'(1));
        if (last_idx_q.size() > 0)
            check({tag, "_last_index"}, 64'(last_idx_q[0]), 64'(DEPTH - 1));
        check({tag, "_reads"}, 64'(rd_addr_q.size()), 64'(DEPTH));
        for (int i = 0; i < DEPTH && i < rd_addr_q.size(); i++)
            check($sformatf("%s_rdaddr%0d", tag, i), 64'(rd_addr_q[i]), 64'(i));
        check({tag, "_stable"}, 64'(stab_err), 64'(0));
        check({tag, "_room"}, 64'(room_err), 64'(0));
        check({tag, "_valid"}, 64'(valid_err), 64'(0));
        check({tag, "_state"}, 64'(dbg_state), 64'(DONE));
`ifdef RAM_DRAIN_SUM_EN
        check({tag, "_sum"}, 64'(sum), exp_sum);
`endif
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'(i + 1);

        // reset state
        repeat (3) @(posedge clock);
        #2;
        check("rst_finish", 64'(finish), 64'(0));
        check("rst_rd_en", 64'(rd_en), 64'(0));
        check("rst_rd_addr", 64'(rd_addr), 64'(0));
        check("rst_valid", 64'(s_if.m_valid), 64'(0));
        check("rst_last", 64'(s_if.m_last), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        @(posedge clock);
        #1 reset_n = 1'b1;

        // 1: full-rate drain of 1..64
        ready_mode = 1;
        clear_logs();
        pulse_start();
        wait_finish("t1");
        check_stream("t1");
        check("t1_first_rd", 64'(first_rd - t0), 64'(1));
        if (hs_cyc_q.size() == DEPTH) begin
            check("t1_back_to_back", 64'(hs_cyc_q[DEPTH-1] - hs_cyc_q[0]), 64'(DEPTH - 1));
            check("t1_finish_cycle", 64'(fin_cyc), 64'(hs_cyc_q[DEPTH-1] + 1));
        end
`ifdef RAM_DRAIN_SUM_EN
        check("t1_sum_const", 64'(sum), 64'd2080);
`endif

        // 2: toggling ready, restart from DONE
        ready_mode = 2;
        clear_logs();
        pulse_start();
        check("t2_left_done", 64'(finish), 64'(0));
        wait_finish("t2");
        check_stream("t2");

        // 3: stalled consumer, start during RUN ignored
        ready_mode = 0;
        clear_logs();
        pulse_start();
        repeat (10) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (9) @(posedge clock);
        #2;
        check("t3_reads", 64'(rd_addr_q.size()), 64'(2));
        if (rd_addr_q.size() == 2) begin
            check("t3_addr0", 64'(rd_addr_q[0]), 64'(0));
            check("t3_addr1", 64'(rd_addr_q[1]), 64'(1));
        end
        check("t3_valid", 64'(s_if.m_valid), 64'(1));
        check("t3_data", 64'(s_if.m_data), 64'(1));
        check("t3_no_beats", 64'(got_q.size()), 64'(0));
        ready_mode = 1;
        wait_finish("t3");
        check_stream("t3");

        // 4: random data and ready, reset mid-transfer
        for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
        ready_mode = 3;
        clear_logs();
        pulse_start();
        for (int n = 0; n < 1000 && got_q.size() < 30; n++) begin
            @(posedge clock);
            #2;
        end
        check("t4_reached_30", 64'(got_q.size() >= 30), 64'(1));
        reset_n = 1'b0;
        @(negedge clock);
        #1;
        check("t4_rst_finish", 64'(finish), 64'(0));
        check("t4_rst_rd_en", 64'(rd_en), 64'(0));
        check("t4_rst_rd_addr", 64'(rd_addr), 64'(0));
        check("t4_rst_valid", 64'(s_if.m_valid), 64'(0));
        check("t4_rst_last", 64'(s_if.m_last), 64'(0));
        check("t4_rst_state", 64'(dbg_state), 64'(IDLE));
`ifdef RAM_DRAIN_SUM_EN
        check("t4_rst_sum", 64'(sum), 64'(0));
`endif
        @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        check("t4_idle_hold", 64'(dbg_state), 64'(IDLE));
        clear_logs();
        pulse_start();
        wait_finish("t4");
        check_stream("t4");

        // 5: all-ones data, restart from DONE, start during RUN ignored
        for (int i = 0; i < DEPTH; i++) ram[i] = '1;
        ready_mode = 3;
        clear_logs();
        pulse_start();
        repeat (20) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_finish("t5");
        check_stream("t5");
`ifdef RAM_DRAIN_SUM_EN
        check("t5_sum_const", 64'(sum), 64'h3F_FFFF_FFC0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global bound so a stuck design still reaches a verdict.
    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
